// File: rtl/enet_rx_buf_pkg.sv
// Shared types and widths for the receive frame buffer controller.
// Write-side FSM encoding plus the frame-length and byte-lane widths.
package enet_rx_buf_pkg;

   localparam int unsigned LEN_W  = 11;
   localparam int unsigned LANE_W = 2;

   typedef enum logic [1:0] {
      StIdle,
      StRecv,
      StDrop
   } wr_state_e;

endpackage

// File: rtl/enet_dp_ram.sv
// Dual-port word RAM: port 0 is write-only, port 1 reads with one-cycle latency
// and can also write. Intended for a single clock driven onto both clock ports.
module enet_dp_ram #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 9
) (
   input  logic              clk0_i,
   input  logic              wr0_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [WIDTH-1:0]  wdata0_i,
   input  logic              clk1_i,
   input  logic              wr1_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [WIDTH-1:0]  wdata1_i,
   output logic [WIDTH-1:0]  rdata1_o
);

   logic [WIDTH-1:0] mem_q [2**ADDR_W];
   logic [WIDTH-1:0] rdata1_q;

   // Both write ports share one process so the array has a single driver.
   always_ff @(posedge clk0_i) begin
      if (wr0_i) mem_q[addr0_i] <= wdata0_i;
      if (wr1_i) mem_q[addr1_i] <= wdata1_i;
   end

   always_ff @(posedge clk1_i) begin
      rdata1_q <= mem_q[addr1_i];
   end

   assign rdata1_o = rdata1_q;

endmodule

// File: rtl/enet_rx_buf_ctrl.sv
// Receive frame buffer: packs MAC bytes into 32-bit RAM words, commits only good
// frames and hands committed frames one at a time to a word-addressed reader.
module enet_rx_buf_ctrl
   import enet_rx_buf_pkg::*;
#(
   parameter int unsigned ADDR_W      = 9,
   parameter int unsigned LEN_DEPTH_W = 3,
   parameter int unsigned MAX_LEN     = 1518
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   input  logic [7:0]        in_data_i,
   input  logic              in_last_i,
   input  logic              in_error_i,
   output logic              rd_frame_valid_o,
   output logic [LEN_W-1:0]  rd_frame_len_o,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [31:0]       rd_data_o,
   input  logic              rd_pop_i,
   output logic [15:0]       stat_drop_o
);

   localparam int unsigned      PtrW      = ADDR_W + 1;
   localparam int unsigned      FifoDepth = 2 ** LEN_DEPTH_W;
   localparam logic [LEN_W-1:0] MaxLen    = LEN_W'(MAX_LEN);
   localparam logic [PtrW-1:0]  RamWords  = PtrW'(2 ** ADDR_W);

   wr_state_e             state_q, state_d;
   logic [LANE_W-1:0]     lane_q, lane_d;
   logic [LEN_W-1:0]      byte_cnt_q, byte_cnt_d;
   logic [23:0]           acc_q, acc_d;
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]       cmt_ptr_q, cmt_ptr_d;
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LEN_W-1:0]      len_mem_q [FifoDepth];
   logic [LEN_W-1:0]      len_mem_d [FifoDepth];
   logic [LEN_DEPTH_W:0]  fifo_wr_q, fifo_wr_d;
   logic [LEN_DEPTH_W:0]  fifo_rd_q, fifo_rd_d;
   logic [15:0]           stat_q, stat_d;
   logic                  rd_seen_q, rd_seen_d;

   logic                  ram_we;
   logic [31:0]           ram_wdata;
   logic [31:0]           ram_rdata;
   logic [ADDR_W-1:0]     ram_raddr;
   logic                  fifo_empty, fifo_full, ram_full, pop;
   logic [LEN_W-1:0]      head_len;
   logic [LANE_W-1:0]     lane;
   logic [LEN_W-1:0]      cnt_nxt;
   logic                  need_write, overflow;

   assign fifo_empty = (fifo_wr_q == fifo_rd_q);
   assign fifo_full  = (fifo_wr_q[LEN_DEPTH_W] != fifo_rd_q[LEN_DEPTH_W]) &&
                       (fifo_wr_q[LEN_DEPTH_W-1:0] == fifo_rd_q[LEN_DEPTH_W-1:0]);
   assign ram_full   = ((wr_ptr_q - rd_ptr_q) == RamWords);
   assign head_len   = len_mem_q[fifo_rd_q[LEN_DEPTH_W-1:0]];
   assign pop        = rd_pop_i && !fifo_empty;
   assign ram_raddr  = rd_ptr_q[ADDR_W-1:0] + rd_addr_i;

   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      byte_cnt_d = byte_cnt_q;
      acc_d      = acc_q;
      wr_ptr_d   = wr_ptr_q;
      cmt_ptr_d  = cmt_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_wr_d  = fifo_wr_q;
      fifo_rd_d  = fifo_rd_q;
      len_mem_d  = len_mem_q;
      stat_d     = stat_q;
      ram_we     = 1'b0;
      ram_wdata  = '0;

      // A byte seen in IDLE is always the first of a frame.
      lane       = (state_q == StIdle) ? '0 : lane_q;
      cnt_nxt    = (state_q == StIdle) ? LEN_W'(1) : byte_cnt_q + LEN_W'(1);
      need_write = (lane == LANE_W'(3)) || in_last_i;
      overflow   = ((state_q == StIdle) && fifo_full) || (cnt_nxt > MaxLen) ||
                   (need_write && ram_full);

      unique case (lane)
         2'd0:    ram_wdata = {24'h0, in_data_i};
         2'd1:    ram_wdata = {16'h0, in_data_i, acc_q[7:0]};
         2'd2:    ram_wdata = {8'h0, in_data_i, acc_q[15:0]};
         default: ram_wdata = {in_data_i, acc_q};
      endcase

      unique case (state_q)
         StIdle, StRecv: begin
            if (in_valid_i) begin
               acc_d      = ram_wdata[23:0];
               byte_cnt_d = cnt_nxt;
               lane_d     = need_write ? '0 : lane + LANE_W'(1);
               if (overflow || (in_last_i && in_error_i)) begin
                  wr_ptr_d = cmt_ptr_q;
                  if (in_last_i) begin
                     stat_d  = (stat_q == 16'hFFFF) ? stat_q : stat_q + 16'd1;
                     state_d = StIdle;
                  end else begin
                     state_d = StDrop;
                  end
               end else begin
                  state_d = in_last_i ? StIdle : StRecv;
                  if (need_write) begin
                     ram_we   = 1'b1;
                     wr_ptr_d = wr_ptr_q + PtrW'(1);
                  end
                  if (in_last_i) begin
                     cmt_ptr_d = wr_ptr_q + PtrW'(1);
                     len_mem_d[fifo_wr_q[LEN_DEPTH_W-1:0]] = cnt_nxt;
                     fifo_wr_d = fifo_wr_q + (LEN_DEPTH_W+1)'(1);
                  end
               end
            end
         end
         StDrop: begin
            if (in_valid_i && in_last_i) begin
               stat_d  = (stat_q == 16'hFFFF) ? stat_q : stat_q + 16'd1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (pop) begin
         rd_ptr_d  = rd_ptr_q + PtrW'((head_len + LEN_W'(3)) >> 2);
         fifo_rd_d = fifo_rd_q + (LEN_DEPTH_W+1)'(1);
      end
   end

   // Data is forced to zero unless a frame was available when the address was sampled.
   assign rd_seen_d = !fifo_empty;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         lane_q     <= '0;
         byte_cnt_q <= '0;
         acc_q      <= '0;
         wr_ptr_q   <= '0;
         cmt_ptr_q  <= '0;
         rd_ptr_q   <= '0;
         len_mem_q  <= '{default: '0};
         fifo_wr_q  <= '0;
         fifo_rd_q  <= '0;
         stat_q     <= '0;
         rd_seen_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         byte_cnt_q <= byte_cnt_d;
         acc_q      <= acc_d;
         wr_ptr_q   <= wr_ptr_d;
         cmt_ptr_q  <= cmt_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         len_mem_q  <= len_mem_d;
         fifo_wr_q  <= fifo_wr_d;
         fifo_rd_q  <= fifo_rd_d;
         stat_q     <= stat_d;
         rd_seen_q  <= rd_seen_d;
      end
   end

   enet_dp_ram #(
      .WIDTH  (32),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk0_i   (clk_i),
      .wr0_i    (ram_we),
      .addr0_i  (wr_ptr_q[ADDR_W-1:0]),
      .wdata0_i (ram_wdata),
      .clk1_i   (clk_i),
      .wr1_i    (1'b0),
      .addr1_i  (ram_raddr),
      .wdata1_i (32'h0),
      .rdata1_o (ram_rdata)
   );

   assign rd_frame_valid_o = !fifo_empty;
   assign rd_frame_len_o   = fifo_empty ? '0 : head_len;
   assign rd_data_o        = rd_seen_q ? ram_rdata : '0;
   assign stat_drop_o      = stat_q;

endmodule

// File: tb/tb_enet_rx_buf_ctrl.sv
// Randomized bench for enet_rx_buf_ctrl: a 512-word and a 16-word instance see the
// same byte stream; a frame-level model predicts what each one commits or drops.
module tb_enet_rx_buf_ctrl;

   localparam int MaxLen = 1518;
   localparam int Depth  = 8;

   int ram_words [2] = '{512, 16};

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_last, in_error;
   logic [7:0]       in_data;
   logic [1:0][8:0]  rd_addr;
   logic [1:0]       rd_pop;
   logic [1:0]       frame_valid;
   logic [1:0][10:0] frame_len;
   logic [1:0][31:0] rd_data;
   logic [1:0][15:0] stat;

   // Reference model: committed frame lengths, their bytes, words held, drop count.
   int         lq [2][$];
   logic [7:0] mq [2][$];
   int         used [2];
   int         drops [2];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   enet_rx_buf_ctrl u_dut_big (
      .clk_i            (clk),
      .rst_i            (rst),
      .in_valid_i       (in_valid),
      .in_data_i        (in_data),
      .in_last_i        (in_last),
      .in_error_i       (in_error),
      .rd_frame_valid_o (frame_valid[0]),
      .rd_frame_len_o   (frame_len[0]),
      .rd_addr_i        (rd_addr[0]),
      .rd_data_o        (rd_data[0]),
      .rd_pop_i         (rd_pop[0]),
      .stat_drop_o      (stat[0])
   );

   enet_rx_buf_ctrl #(
      .ADDR_W (4)
   ) u_dut_small (
      .clk_i            (clk),
      .rst_i            (rst),
      .in_valid_i       (in_valid),
      .in_data_i        (in_data),
      .in_last_i        (in_last),
      .in_error_i       (in_error),
      .rd_frame_valid_o (frame_valid[1]),
      .rd_frame_len_o   (frame_len[1]),
      .rd_addr_i        (rd_addr[1][3:0]),
      .rd_data_o        (rd_data[1]),
      .rd_pop_i         (rd_pop[1]),
      .stat_drop_o      (stat[1])
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int n, input bit err);
      logic [7:0] fb [$];
      for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
      for (int i = 0; i < n; i++) begin
         while ($urandom_range(0, 3) == 0) tick();
         in_valid = 1'b1;
         in_data  = fb[i];
         in_last  = (i == n - 1);
         in_error = err && (i == n - 1);
         tick();
         in_valid = 1'b0;
         in_last  = 1'b0;
         in_error = 1'b0;
      end
      for (int d = 0; d < 2; d++) begin
         int w;
         w = (n + 3) / 4;
         if (lq[d].size() == Depth || err || n > MaxLen || w > ram_words[d] - used[d]) begin
            if (drops[d] < 65535) drops[d]++;
         end else begin
            lq[d].push_back(n);
            used[d] += w;
            foreach (fb[i]) mq[d].push_back(fb[i]);
         end
      end
   endtask

   // Reads every word of the head frame, compares it, then pops it.
   task automatic check_head(input int d);
      int          n, w;
      logic [31:0] exp;
      if (lq[d].size() == 0) begin
         check_eq($sformatf("d%0d_valid_empty", d), 32'(frame_valid[d]), 32'd0);
         check_eq($sformatf("d%0d_len_empty", d), 32'(frame_len[d]), 32'd0);
         return;
      end
      n = lq[d].pop_front();
      w = (n + 3) / 4;
      check_eq($sformatf("d%0d_valid", d), 32'(frame_valid[d]), 32'd1);
      check_eq($sformatf("d%0d_len", d), 32'(frame_len[d]), 32'(n));
      for (int k = 0; k < w; k++) begin
         rd_addr[d] = 9'(k);
         tick();
         exp = '0;
         for (int b = 0; b < 4; b++) begin
            if (4 * k + b < n) exp[8*b +: 8] = mq[d].pop_front();
         end
         check_eq($sformatf("d%0d_word%0d_of_len%0d", d, k, n), rd_data[d], exp);
      end
      rd_pop[d] = 1'b1;
      tick();
      rd_pop[d] = 1'b0;
      used[d] -= w;
   endtask

   task automatic drain_all();
      for (int d = 0; d < 2; d++) begin
         while (lq[d].size() > 0) check_head(d);
         check_head(d);
         check_eq($sformatf("d%0d_stat_drop", d), 32'(stat[d]), 32'(drops[d]));
      end
   endtask

   task automatic check_reset_outputs();
      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("d%0d_rst_valid", d), 32'(frame_valid[d]), 32'd0);
         check_eq($sformatf("d%0d_rst_len", d), 32'(frame_len[d]), 32'd0);
         check_eq($sformatf("d%0d_rst_data", d), rd_data[d], 32'd0);
         check_eq($sformatf("d%0d_rst_stat", d), 32'(stat[d]), 32'd0);
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      in_error = 1'b0;
      rd_addr  = '0;
      rd_pop   = '0;
      for (int d = 0; d < 2; d++) begin
         used[d]  = 0;
         drops[d] = 0;
      end
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_reset_outputs();

      send_frame(64, 1'b0);
      drain_all();

      send_frame(61, 1'b0);
      send_frame(8, 1'b0);
      drain_all();

      send_frame(30, 1'b0);
      send_frame(25, 1'b1);
      send_frame(17, 1'b0);
      drain_all();

      // Second 40-byte frame overflows the 16-word instance; the third wraps its RAM.
      send_frame(40, 1'b0);
      send_frame(40, 1'b0);
      check_head(0);
      check_head(1);
      send_frame(40, 1'b0);
      drain_all();

      for (int i = 0; i < Depth + 1; i++) send_frame(int'($urandom_range(1, 8)), 1'b0);
      drain_all();

      send_frame(MaxLen + 1, 1'b0);
      send_frame(MaxLen, 1'b0);
      drain_all();

      repeat (40) begin
         int n;
         bit err;
         n   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1400, MaxLen + 2))
                                           : int'($urandom_range(1, 70));
         err = ($urandom_range(0, 7) == 0);
         send_frame(n, err);
         if ($urandom_range(0, 2) == 0) begin
            check_head(0);
            check_head(1);
         end
      end
      drain_all();

      // Reset in the middle of a frame with frames still queued.
      send_frame(12, 1'b0);
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         tick();
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         lq[d].delete();
         mq[d].delete();
         used[d]  = 0;
         drops[d] = 0;
      end
      tick();
      check_reset_outputs();
      send_frame(12, 1'b0);
      drain_all();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
